// File: rtl/ula_serial_alu.sv
// ula_serial_alu: multi-cycle 74181-style ALU processing WIDTH bits in SLICE_W-bit slices, LSB first.
// Optional two's-complement overflow output under `ifdef ULA_OVERFLOW_EN.
module ula_serial_alu #(
    parameter int WIDTH   = 8,
    parameter int SLICE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             c_in,
    output logic [WIDTH-1:0] f,
    output logic             a_eq_b,
    output logic             c_out,
    output logic             busy,
`ifdef ULA_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             done
);
    localparam int NUM_SLICES = WIDTH / SLICE_W;
    localparam int IDX_W = NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SLICES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, f_q, f_d;
    logic [3:0]         s_q, s_d;
    logic               m_q, m_d, carry_q, carry_d, eq_q, eq_d;
    logic               c_out_q, c_out_d, a_eq_b_q, a_eq_b_d, done_q, done_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        sh;
    logic [SLICE_W-1:0] a_sl, b_sl, x, y, sl_f;
    logic [SLICE_W:0]   sum;
    logic               sl_c, eq_n;
    logic [WIDTH-1:0]   merged;

    // Slice datapath: operates on the slice selected by idx_q.
    always_comb begin
        sh     = 32'(idx_q) * SLICE_W;
        a_sl   = SLICE_W'(a_q >> sh);
        b_sl   = SLICE_W'(b_q >> sh);
        x      = a_sl | ({SLICE_W{s_q[0]}} & b_sl) | ({SLICE_W{s_q[1]}} & ~b_sl);
        y      = a_sl & (({SLICE_W{s_q[2]}} & ~b_sl) | ({SLICE_W{s_q[3]}} & b_sl));
        sum    = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, carry_q};
        sl_f   = m_q ? ~(x ^ y) : sum[SLICE_W-1:0];
        sl_c   = ~m_q & sum[SLICE_W];
        eq_n   = eq_q & (&sl_f);
        merged = (res_q & ~(WIDTH'({SLICE_W{1'b1}}) << sh)) | (WIDTH'(sl_f) << sh);
    end

`ifdef ULA_OVERFLOW_EN
    logic sl_v, ovf_q, ovf_d;
    // Carry into the slice MSB is recovered from the sum bit; only the last slice's value is kept.
    assign sl_v = ~m_q & (x[SLICE_W-1] ^ y[SLICE_W-1] ^ sum[SLICE_W-1] ^ sum[SLICE_W]);
    assign ovf  = ovf_q;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        m_d      = m_q;
        carry_d  = carry_q;
        eq_d     = eq_q;
        idx_d    = idx_q;
        res_d    = res_q;
        f_d      = f_q;
        c_out_d  = c_out_q;
        a_eq_b_d = a_eq_b_q;
        done_d   = 1'b0;
`ifdef ULA_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        if (state_q == IDLE) begin
            if (start) begin
                a_d     = a;
                b_d     = b;
                s_d     = s;
                m_d     = m;
                carry_d = c_in;
                eq_d    = 1'b1;
                idx_d   = '0;
                state_d = RUN;
            end
        end else begin
            res_d   = merged;
            carry_d = sl_c;
            eq_d    = eq_n;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST) begin
                f_d      = merged;
                c_out_d  = sl_c;
                a_eq_b_d = eq_n;
                done_d   = 1'b1;
                state_d  = IDLE;
`ifdef ULA_OVERFLOW_EN
                ovf_d    = sl_v;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            carry_q  <= 1'b0;
            eq_q     <= 1'b0;
            idx_q    <= '0;
            res_q    <= '0;
            f_q      <= '0;
            c_out_q  <= 1'b0;
            a_eq_b_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef ULA_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            m_q      <= m_d;
            carry_q  <= carry_d;
            eq_q     <= eq_d;
            idx_q    <= idx_d;
            res_q    <= res_d;
            f_q      <= f_d;
            c_out_q  <= c_out_d;
            a_eq_b_q <= a_eq_b_d;
            done_q   <= done_d;
`ifdef ULA_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign f      = f_q;
    assign a_eq_b = a_eq_b_q;
    assign c_out  = c_out_q;
    assign busy   = (state_q == RUN);
    assign done   = done_q;
endmodule

// File: tb/tb_ula_serial_alu.sv
// tb_ula_serial_alu: randomized and directed checks of ula_serial_alu against a whole-word reference model.
module tb_ula_serial_alu;
    localparam int W  = 8;
    localparam int NS = 2;

    logic         clk = 0, rst_n = 0, start = 0, m = 0, c_in = 0;
    logic [W-1:0] a = 0, b = 0;
    logic [3:0]   s = 0;
    logic [W-1:0] f;
    logic         a_eq_b, c_out, busy, done;
`ifdef ULA_OVERFLOW_EN
    logic         ovf;
`endif
    int errors = 0, checks = 0;

    ula_serial_alu #(.WIDTH(W), .SLICE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .s(s), .m(m), .c_in(c_in),
        .f(f), .a_eq_b(a_eq_b), .c_out(c_out), .busy(busy),
`ifdef ULA_OVERFLOW_EN
        .ovf(ovf),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, c_out, f} for a full-width operation.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, mb, input logic [3:0] ms,
                                           input logic mm, mc);
        logic [W-1:0] x, y, r;
        logic [W:0]   sm;
        x = ma | ({W{ms[0]}} & mb) | ({W{ms[1]}} & ~mb);
        y = ma & (({W{ms[2]}} & ~mb) | ({W{ms[3]}} & mb));
        if (mm) return {2'b00, ~(x ^ y)};
        sm = {1'b0, x} + {1'b0, y} + (W+1)'(mc);
        r  = sm[W-1:0];
        return {(x[W-1] == y[W-1]) && (r[W-1] != x[W-1]), sm[W], r};
    endfunction

    task automatic wait_done(input string tag, input int exp_lat);
        int n = 0;
        while (!done && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
    endtask

    task automatic check_result(input string tag, input logic [W+1:0] e);
        chk({tag, "_f"}, f, e[W-1:0]);
        chk({tag, "_cout"}, c_out, e[W]);
        chk({tag, "_eq"}, a_eq_b, &e[W-1:0]);
        chk({tag, "_busy"}, busy, 0);
`ifdef ULA_OVERFLOW_EN
        chk({tag, "_ovf"}, ovf, e[W+1]);
`endif
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, tb, input logic [3:0] ts,
                          input logic tm, tc);
        a = ta; b = tb; s = ts; m = tm; c_in = tc; start = 1;
        @(posedge clk); #1;
        start = 0;
        a = ~ta; b = ~tb;
        chk({tag, "_busy1"}, busy, 1);
        wait_done(tag, NS);
        check_result(tag, model(ta, tb, ts, tm, tc));
    endtask

    initial begin
        logic [W+1:0] e1, e2;
        int cnt;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_f", f, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cout", c_out, 0);
        chk("rst_eq", a_eq_b, 0);
        rst_n = 1;
        @(posedge clk); #1;

        run_op("add", 8'h4C, 8'h3B, 4'b1001, 0, 0);
        chk("add_const", f, 8'h87);
        run_op("carry", 8'hFF, 8'h01, 4'b1001, 0, 0);
        chk("carry_const", {c_out, f}, 9'h100);
        run_op("ovf", 8'h7F, 8'h01, 4'b1001, 0, 0);
        chk("ovf_const", {c_out, f}, 9'h080);
        run_op("cmp_eq", 8'h5A, 8'h5A, 4'b0110, 0, 0);
        chk("cmp_eq_const", {a_eq_b, f}, 9'h1FF);
        run_op("cmp_ne", 8'h5A, 8'h5B, 4'b0110, 0, 0);
        chk("cmp_ne_const", {a_eq_b, f}, 9'h0FE);
        run_op("xor", 8'hF0, 8'h3C, 4'b0110, 1, 0);
        chk("xor_const", f, 8'hCC);
        run_op("not", 8'h0F, 8'h00, 4'b0000, 1, 0);
        chk("not_const", f, 8'hF0);
        run_op("dec", 8'h00, 8'h55, 4'b1111, 0, 0);
        chk("dec_const", f, 8'hFF);

        // start held through RUN with changing operands, then accepted in the done cycle
        e1 = model(8'h12, 8'h34, 4'b1001, 0, 1);
        e2 = model(8'hA5, 8'h0F, 4'b1011, 1, 0);
        a = 8'h12; b = 8'h34; s = 4'b1001; m = 0; c_in = 1; start = 1;
        @(posedge clk); #1;
        a = 8'hA5; b = 8'h0F; s = 4'b1011; m = 1; c_in = 0;
        wait_done("hs1", NS);
        check_result("hs1", e1);
        @(posedge clk); #1;
        start = 0;
        chk("hs_done_pulse", done, 0);
        chk("hs_busy2", busy, 1);
        wait_done("hs2", NS);
        check_result("hs2", e2);

        // asynchronous reset one cycle after acceptance
        a = 8'h33; b = 8'h44; s = 4'b1001; m = 0; c_in = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        rst_n = 0;
        #1;
        chk("mid_rst_f", f, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1;
        cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("mid_rst_nodone", cnt, 0);
        run_op("post_rst", 8'h33, 8'h44, 4'b1001, 0, 0);

        for (int i = 0; i < 40; i++)
            run_op("rnd", W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
